// File: rtl/dm_lsu_pkg.sv
// Shared op/state encodings and the access-size/misalignment rules for the
// data-memory load/store unit.
package dm_lsu_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_SW  = 3'b010,
    OP_LW  = 3'b011,
    OP_LBU = 3'b100,
    OP_LHU = 3'b101,
    OP_SB  = 3'b110,
    OP_SH  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
    logic m;
    case (op)
      OP_LH, OP_LHU, OP_SH: m = lo[0];
      OP_LW, OP_SW:         m = (lo != 2'b00);
      default:              m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic is_sub_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH);
  endfunction

endpackage

// File: rtl/dm_lsu_align.sv
// Byte-lane extract/extend for loads and read-modify-write merge for sub-word stores.
module dm_lsu_align
  import dm_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select addressed lane/half, then extend for loads or splice for stores
  always_comb begin
    byte_s   = word[{addr_lo, 3'b000} +: 8];
    half_s   = addr_lo[1] ? word[31:16] : word[15:0];
    load_val = word;
    merged   = wdata;
    case (op)
      OP_LB:   load_val = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  load_val = {24'h000000, byte_s};
      OP_LH:   load_val = {{16{half_s[15]}}, half_s};
      OP_LHU:  load_val = {16'h0000, half_s};
      default: load_val = word;
    endcase
    case (op)
      OP_SB: begin
        merged = word;
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      OP_SH: begin
        merged = word;
        if (addr_lo[1]) begin
          merged[31:16] = wdata[15:0];
        end else begin
          merged[15:0] = wdata[15:0];
        end
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit sequencing byte/half/word accesses to a word-wide data
// memory; sub-word stores are done as read-modify-write.
module dm_lsu
  import dm_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [9:0]  addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [9:0]  dm_addr,
  output logic [31:0] dm_din,
  output logic        dm_we,
  input  logic [31:0] dm_dout
);

  state_e      state_r;
  logic [2:0]  op_r;
  logic [9:0]  addr_r;
  logic [31:0] wdata_r;
  logic [31:0] word_r;
  logic [31:0] word_s;
  logic [31:0] load_s;
  logic [31:0] merged_s;

  assign dm_addr = {addr_r[9:2], 2'b00};
  // In RD the memory word is live on dm_dout; afterwards use the captured copy
  assign word_s  = (state_r == ST_RD) ? dm_dout : word_r;

  dm_lsu_align u_align (
    .op       (op_r),
    .addr_lo  (addr_r[1:0]),
    .word     (word_s),
    .wdata    (wdata_r),
    .load_val (load_s),
    .merged   (merged_s)
  );

  // Request FSM with all outputs registered on the transition into each state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      op_r    <= 3'b000;
      addr_r  <= 10'h000;
      wdata_r <= 32'h0000_0000;
      word_r  <= 32'h0000_0000;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= 32'h0000_0000;
      dm_din  <= 32'h0000_0000;
      dm_we   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (req) begin
            op_r    <= op;
            addr_r  <= addr;
            wdata_r <= wdata;
            busy    <= 1'b1;
            if (misaligned(op, addr[1:0])) begin
              state_r <= ST_DONE;
              done    <= 1'b1;
              err     <= 1'b1;
            end else if (op == OP_SW) begin
              state_r <= ST_WR;
              dm_we   <= 1'b1;
              dm_din  <= wdata;
            end else begin
              state_r <= ST_RD;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ST_RD: begin
          word_r <= dm_dout;
          if (is_sub_store(op_r)) begin
            state_r <= ST_WR;
            dm_we   <= 1'b1;
            dm_din  <= merged_s;
          end else begin
            state_r <= ST_DONE;
            done    <= 1'b1;
            rdata   <= load_s;
          end
        end
        ST_WR: begin
          dm_we   <= 1'b0;
          state_r <= ST_DONE;
          done    <= 1'b1;
        end
        ST_DONE: begin
          done    <= 1'b0;
          err     <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          err     <= 1'b0;
          dm_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_lsu.sv
// Self-checking bench for dm_lsu: byte-array data memory plus a byte-level
// reference model, directed scenarios and randomized accesses.
module tb_dm_lsu;

  localparam logic [2:0] T_LB = 3'b000, T_LH = 3'b001, T_SW = 3'b010, T_LW = 3'b011;
  localparam logic [2:0] T_LBU = 3'b100, T_LHU = 3'b101, T_SB = 3'b110, T_SH = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [2:0]  op;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic        busy, done, err, dm_we;
  logic [31:0] rdata, dm_din, dm_dout;
  logic [9:0]  dm_addr;

  logic [7:0]  mem [1024];
  logic [7:0]  ref_mem [1024];
  logic [31:0] ref_rdata;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  dm_lsu dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
  );

  assign dm_dout = {mem[{dm_addr[9:2], 2'd3}], mem[{dm_addr[9:2], 2'd2}],
                    mem[{dm_addr[9:2], 2'd1}], mem[{dm_addr[9:2], 2'd0}]};

  always @(posedge clk) begin
    if (dm_we) begin
      mem[{dm_addr[9:2], 2'd0}] <= dm_din[7:0];
      mem[{dm_addr[9:2], 2'd1}] <= dm_din[15:8];
      mem[{dm_addr[9:2], 2'd2}] <= dm_din[23:16];
      mem[{dm_addr[9:2], 2'd3}] <= dm_din[31:24];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input int a);
    int b = a - (a % 4);
    return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
  endfunction

  function automatic logic [31:0] ref_word(input int a);
    int b = a - (a % 4);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  // Reference: access size, alignment by modulo, byte-wise load/store
  task automatic model(input logic [2:0] o, input int a, input logic [31:0] wd,
                       output logic mis, output logic st, output int lat);
    int size;
    logic [31:0] v;
    size = (o == T_LB || o == T_LBU || o == T_SB) ? 1 :
           (o == T_LH || o == T_LHU || o == T_SH) ? 2 : 4;
    st   = (o == T_SB || o == T_SH || o == T_SW);
    mis  = (a % size) != 0;
    if (mis) begin
      lat = 1;
    end else if (!st) begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
      if ((o == T_LB || o == T_LH) && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      ref_rdata = v;
      lat = 2;
    end else begin
      for (int i = 0; i < size; i++) ref_mem[a+i] = 8'((wd >> (8*i)) & 32'hFF);
      lat = (size == 4) ? 2 : 3;
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [9:0] a, input logic [31:0] wd);
    int lat, exp_lat;
    logic mis, st, we_seen, err_at_done;
    model(o, int'(a), wd, mis, st, exp_lat);
    @(negedge clk);
    req = 1'b1; op = o; addr = a; wdata = wd;
    @(posedge clk);
    #1 req = 1'b0;
    we_seen = 1'b0; err_at_done = 1'b0; lat = 99;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (dm_we) we_seen = 1'b1;
      if (done) begin
        lat = c;
        err_at_done = err;
        break;
      end
      @(posedge clk);
    end
    chk($sformatf("lat op=%0d a=%h", o, a), 32'(lat), 32'(exp_lat));
    chk($sformatf("err op=%0d a=%h", o, a), 32'(err_at_done), 32'(mis));
    chk($sformatf("we op=%0d a=%h", o, a), 32'(we_seen), 32'(st && !mis));
    chk($sformatf("rdata op=%0d a=%h", o, a), rdata, ref_rdata);
    chk($sformatf("mem op=%0d a=%h", o, a), mem_word(int'(a)), ref_word(int'(a)));
  endtask

  initial begin
    logic [7:0] b;
    logic [2:0] o;
    logic [9:0] a;
    logic [7:0] orig;
    logic mis, st;
    int lat;
    rst = 1'b1; req = 1'b0; op = 3'b000; addr = 10'h000; wdata = 32'h0;
    ref_rdata = 32'h0;
    for (int i = 0; i < 1024; i++) begin
      b = 8'($urandom);
      mem[i] = b;
      ref_mem[i] = b;
    end
    repeat (2) @(negedge clk);
    chk("reset_outs", {busy, done, err, dm_we, rdata, dm_din, 22'(dm_addr)},
        {4'b0000, 32'h0, 32'h0, 22'h0});
    rst = 1'b0;

    // Directed scenarios
    run_op(T_SW, 10'h010, 32'h1122_3344);
    chk("sw_bytes", {mem[19], mem[18], mem[17], mem[16]}, 32'h1122_3344);
    run_op(T_LW, 10'h010, 32'h0);
    chk("lw_rdata", rdata, 32'h1122_3344);
    run_op(T_LB, 10'h013, 32'h0);
    chk("lb_rdata", rdata, 32'h0000_0011);
    run_op(T_SB, 10'h012, 32'h0000_00FF);
    run_op(T_LW, 10'h010, 32'h0);
    chk("sb_merge", rdata, 32'h11FF_3344);
    run_op(T_SW, 10'h010, 32'h8001_0000);
    run_op(T_LH, 10'h012, 32'h0);
    chk("lh_sext", rdata, 32'hFFFF_8001);
    run_op(T_LHU, 10'h012, 32'h0);
    chk("lhu_zext", rdata, 32'h0000_8001);
    run_op(T_SH, 10'h011, 32'h0000_1234);
    chk("sh_mis_rdata", rdata, 32'h0000_8001);
    chk("sh_mis_mem", {mem[19], mem[18], mem[17], mem[16]}, 32'h8001_0000);
    run_op(T_SW, 10'h3FC, 32'hCAFE_BABE);
    run_op(T_LB, 10'h3FF, 32'h0);
    run_op(T_SH, 10'h3FE, 32'h0000_5A5A);
    run_op(T_LW, 10'h3FC, 32'h0);

    // req held high: one accept every 3 cycles, busy low only on accept cycles
    @(negedge clk);
    req = 1'b1; op = T_LW; addr = 10'h010; wdata = 32'h0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("hold_busy%0d", i), 32'(busy), 32'((i % 3) != 0));
      chk($sformatf("hold_done%0d", i), 32'(done), 32'((i % 3) == 2));
    end
    req = 1'b0;
    model(T_LW, 16, 32'h0, mis, st, lat);
    chk("hold_rdata", rdata, ref_rdata);

    // Reset during the write cycle of an SB
    orig = ref_mem[10'h021];
    @(negedge clk);
    req = 1'b1; op = T_SB; addr = 10'h021; wdata = {24'h0, ~orig};
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (dm_we) begin
        lat = c;
        break;
      end
    end
    chk("rst_we_reached", 32'(lat), 32'd2);
    rst = 1'b1;
    #1;
    chk("rst_we_drop", 32'(dm_we), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_outs", {busy, done, err, dm_we, rdata, dm_din, 22'(dm_addr)},
        {4'b0000, 32'h0, 32'h0, 22'h0});
    chk("rst_byte", 32'(mem[10'h021]), 32'(orig));
    rst = 1'b0;
    ref_rdata = 32'h0;
    run_op(T_LW, 10'h020, 32'h0);

    // Randomized accesses, biased toward a small window for read-after-write hits
    for (int n = 0; n < 200; n++) begin
      o = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 31)) : 10'($urandom_range(0, 1023));
      run_op(o, a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
